mc_ctrl: RTL

- Multi-cycle MIPS-subset control FSM that sits on the driving end of the ALU interface.
- Decodes opcode/funct from the instruction register and sequences FETCH/DECODE/EXEC/MEM/WB.
- Drives alu_op and all datapath enables; consumes the ALU equality flag to resolve beq.
- Replaces the single-cycle combinational controller in the multi-cycle datapath.

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/mc_ctrl_if.sv | 33 +++
 rtl/mc_decode.sv | 32 +++
 rtl/mc_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-subset controller: ALU op codes,
// state encodings, opcode/funct values and the decoded instruction class.
package mc_ctrl_pkg;

   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam logic [4:0] ALU_ORI = 5'd2;
   localparam logic [4:0] ALU_SLL = 5'd3;
   localparam logic [4:0] ALU_LUI = 5'd4;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;

   typedef enum logic [3:0] {
      C_NONE, C_ADD, C_SUB, C_SLL, C_ORI, C_LUI, C_LW, C_SW, C_BEQ
   } cls_t;

   typedef struct packed {
      logic       ir_we;
      logic       pc_we;
      logic       pc_sel;
      logic [4:0] alu_op;
      logic [1:0] alu_b_sel;
      logic       reg_we;
      logic       reg_dst;
      logic       wd_sel;
      logic       mem_we;
      logic       instr_done;
   } ctrl_t;

   function automatic logic [4:0] exec_alu_op(cls_t c);
      case (c)
         C_SUB, C_BEQ: return ALU_SUB;
         C_SLL:        return ALU_SLL;
         C_ORI:        return ALU_ORI;
         C_LUI:        return ALU_LUI;
         default:      return ALU_ADD;
      endcase
   endfunction

   // 0 = rt data, 1 = sign-extended imm, 2 = zero-extended imm
   function automatic logic [1:0] exec_b_sel(cls_t c);
      case (c)
         C_LW, C_SW:   return 2'd1;
         C_ORI, C_LUI: return 2'd2;
         default:      return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and status in, state/enables/selects out.
import mc_ctrl_pkg::*;

interface mc_ctrl_if #(parameter int ALU_OP_W = 5);
   logic [5:0]          opcode;
   logic [5:0]          funct;
   logic                branch_eq;
   logic                mem_ready;
   logic [2:0]          state;
   logic                ir_we;
   logic                pc_we;
   logic                pc_sel;
   logic [ALU_OP_W-1:0] alu_op;
   logic [1:0]          alu_b_sel;
   logic                reg_we;
   logic                reg_dst;
   logic                wd_sel;
   logic                mem_we;
   logic                instr_done;
   logic                illegal;

   modport master (
      input  opcode, funct, branch_eq, mem_ready,
      output state, ir_we, pc_we, pc_sel, alu_op, alu_b_sel,
             reg_we, reg_dst, wd_sel, mem_we, instr_done, illegal
   );

   modport slave (
      output opcode, funct, branch_eq, mem_ready,
      input  state, ir_we, pc_we, pc_sel, alu_op, alu_b_sel,
             reg_we, reg_dst, wd_sel, mem_we, instr_done, illegal
   );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct -> class, plus unsupported flag.
import mc_ctrl_pkg::*;

module mc_decode (
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output cls_t       cls,
   output logic       illegal
);

   always_comb begin
      cls     = C_NONE;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  cls = C_ADD;
               FN_SUB:  cls = C_SUB;
               FN_SLL:  cls = C_SLL;
               default: illegal = 1'b1;
            endcase
         end
         OP_ORI:  cls = C_ORI;
         OP_LUI:  cls = C_LUI;
         OP_LW:   cls = C_LW;
         OP_SW:   cls = C_SW;
         OP_BEQ:  cls = C_BEQ;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM driving the ALU and datapath enables.
// Optional ILLEGAL_TRAP_EN: unsupported instructions park the FSM in HALT.
//
// state  | meaning
// FETCH  | load IR, PC <= PC+4
// DECODE | classify IR, latch class
// EXEC   | ALU operation; beq resolves and completes here
// MEM    | lw/sw access, held until mem_ready
// WB     | register file write, instruction completes
// HALT   | trapped on unsupported instruction, held until reset
import mc_ctrl_pkg::*;

module mc_ctrl #(
   parameter int ALU_OP_W = 5
) (
   input logic       clk,
   input logic       reset,
   mc_ctrl_if.master bus
);

   state_t state_q, state_d;
   cls_t   cls_q;
   cls_t   dec_cls;
   logic   dec_ill;
   ctrl_t  ctrl;

   mc_decode u_decode (
      .opcode  (bus.opcode),
      .funct   (bus.funct),
      .cls     (dec_cls),
      .illegal (dec_ill)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         cls_q   <= C_NONE;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE)
            cls_q <= dec_cls;
      end
   end

   always_comb begin
      state_d     = state_q;
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ctrl.ir_we = 1'b1;
            ctrl.pc_we = 1'b1;
            state_d    = S_DECODE;
         end
         S_DECODE: begin
            if (dec_ill) begin
`ifdef ILLEGAL_TRAP_EN
               state_d = S_HALT;
`else
               ctrl.instr_done = 1'b1;
               state_d         = S_FETCH;
`endif
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            ctrl.alu_op    = exec_alu_op(cls_q);
            ctrl.alu_b_sel = exec_b_sel(cls_q);
            case (cls_q)
               C_LW, C_SW: state_d = S_MEM;
               C_BEQ: begin
                  ctrl.pc_we      = bus.branch_eq;
                  ctrl.pc_sel     = 1'b1;
                  ctrl.instr_done = 1'b1;
                  state_d         = S_FETCH;
               end
               C_NONE:  state_d = S_FETCH;
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            ctrl.mem_we = (cls_q == C_SW);
            if (bus.mem_ready) begin
               if (cls_q == C_SW) begin
                  ctrl.instr_done = 1'b1;
                  state_d         = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            ctrl.reg_we     = 1'b1;
            ctrl.instr_done = 1'b1;
            ctrl.reg_dst    = (cls_q == C_ADD) || (cls_q == C_SUB) || (cls_q == C_SLL);
            ctrl.wd_sel     = (cls_q == C_LW);
            state_d         = S_FETCH;
         end
         S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d = S_FETCH;
`endif
         end
         default: state_d = S_FETCH;
      endcase

      // reset aborts the current instruction: nothing may be written this cycle
      if (reset) begin
         ctrl        = '0;
         ctrl.alu_op = ALU_ADD;
      end
   end

   assign bus.state      = state_q;
   assign bus.ir_we      = ctrl.ir_we;
   assign bus.pc_we      = ctrl.pc_we;
   assign bus.pc_sel     = ctrl.pc_sel;
   assign bus.alu_op     = ALU_OP_W'(ctrl.alu_op);
   assign bus.alu_b_sel  = ctrl.alu_b_sel;
   assign bus.reg_we     = ctrl.reg_we;
   assign bus.reg_dst    = ctrl.reg_dst;
   assign bus.wd_sel     = ctrl.wd_sel;
   assign bus.mem_we     = ctrl.mem_we;
   assign bus.instr_done = ctrl.instr_done;

`ifdef ILLEGAL_TRAP_EN
   assign bus.illegal = (state_q == S_HALT) && !reset;
`else
   assign bus.illegal = 1'b0;
`endif

endmodule
